// File: rtl/gray_pkg.sv
// Shared types and default sizes for the Gray-code stream decoder.
package gray_pkg;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_t;

  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_CNT_W = 8;

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Stream bundle between a Gray-coded source, the decoder and its binary consumer.
// master = source/consumer side, slave = decoder side.
interface gray_stream_decoder_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = GRAY_CNT_W
);

  logic             in_valid;
  logic [WIDTH-1:0] in_gray;
  logic             in_ready;
  logic             resync;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_gray, resync, out_ready,
    input  in_ready, out_valid, out_bin, out_err, err_count
  );

  modport slave (
    input  in_valid, in_gray, resync, out_ready,
    output in_ready, out_valid, out_bin, out_err, err_count
  );

endinterface

// File: rtl/gray_to_bin_comb.sv
// Purely combinational Gray-to-binary conversion.
module gray_to_bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Gray-code stream decoder with single-bit adjacency checking and a one-deep output register.
// Define GRAY_ERR_CNT_EN to build the saturating error counter; otherwise err_count reads 0.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = GRAY_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_stream_decoder_if.slave bus
);

  localparam int PW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] conv_bin;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] out_bin_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic             in_ready;
  logic             accept;
  logic             step_err;
  logic [PW-1:0]    pop;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_conv (
    .gray (bus.in_gray),
    .bin  (conv_bin)
  );

  assign in_ready      = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready;
  assign diff          = bus.in_gray ^ prev_gray;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

  // A resync arriving with a sample makes that sample the unchecked first one.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(diff[i]);
    end
    step_err = (state == ST_LOCKED) && !bus.resync && (pop != PW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_UNLOCKED;
      prev_gray   <= '0;
      out_bin_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state       <= ST_LOCKED;
      prev_gray   <= bus.in_gray;
      out_bin_q   <= conv_bin;
      out_err_q   <= step_err;
      out_valid_q <= 1'b1;
    end else begin
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.resync) begin
        state <= ST_UNLOCKED;
      end
    end
  end

`ifdef GRAY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && step_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule
